// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
//   Parametrised UART receiver. It has an rx synchroniser, a 3-sample majority
//   vote around mid-bit, optional parity, 1 or 2 stop bits, break detection and
//   an overrun pulse. os_tick is the only thing that advances the bit timing.
//
//   Build option: define UART_RX_FIFO_EN to get a FIFO_DEPTH-entry receive
//   FIFO. FIFO_DEPTH must be a power of 2 and at least 2. Without the macro,
//   a single holding register is used and FIFO_DEPTH is ignored.
//
// Ports
//   clk, reset           system clock, synchronous active-high reset
//   os_tick              1-cycle enable, OSR pulses per bit time
//   rx                   asynchronous serial line, idle high
//   parity_en/odd        parity configuration (odd=1: odd parity)
//   two_stop             check two stop bits
//   rx_valid/rx_ready    word handshake; a pop happens on valid & ready
//   rx_data              received word, LSB received first
//   parity_err           flag for the presented word
//   frame_err            flag for the presented word
//   break_det            flag for the presented word
//   overrun              1-cycle pulse when a completed word is dropped
// -----------------------------------------------------------------------------
module uart_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int OSR         = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 os_tick,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int CW = $clog2(OSR);
  localparam int BW = $clog2(DATA_BITS);
  localparam int WW = DATA_BITS + 3;  // {break, frame, parity, data}

  localparam logic [CW-1:0] VOTE_A = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] VOTE_B = CW'(OSR / 2);
  localparam logic [CW-1:0] VOTE_C = CW'(OSR / 2 + 1);
  localparam logic [CW-1:0] LAST   = CW'(OSR - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_e;

  // Synchroniser. It resets to the idle-high level so that reset does not
  // look like a start bit.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end
  assign rxs = sync_q[SYNC_STAGES-1];

  state_e               state_q, state_d;
  logic [CW-1:0]        os_cnt_q, os_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           samp_q, samp_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d, pzero_q, pzero_d;
  logic                 done;
  logic [WW-1:0]        done_word;

  logic at_a, at_b, at_dec, period_end, vote;
  assign at_a       = os_tick && (os_cnt_q == VOTE_A);
  assign at_b       = os_tick && (os_cnt_q == VOTE_B);
  assign at_dec     = os_tick && (os_cnt_q == VOTE_C);
  assign period_end = os_tick && (os_cnt_q == LAST);
  // The third sample is taken live at the decision tick.
  assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      samp_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      pzero_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      samp_q    <= samp_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      pzero_q   <= pzero_d;
    end
  end

  // NOTE: every signal gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    samp_d    = samp_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    pzero_d   = pzero_q;
    done      = 1'b0;
    done_word = '0;

    if (os_tick && state_q != S_IDLE && state_q != S_BRK)
      os_cnt_d = period_end ? '0 : os_cnt_q + 1'b1;
    if (at_a) samp_d[0] = rxs;
    if (at_b) samp_d[1] = rxs;

    unique case (state_q)
      S_IDLE: begin
        if (os_tick && !rxs) begin
          state_d   = S_START;
          os_cnt_d  = '0;
          bit_cnt_d = '0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
          pzero_d   = 1'b1;  // stays 1 when there is no parity bit
        end
      end
      S_START: begin
        if (at_dec && vote) state_d = S_IDLE;  // glitch, not a start bit
        else if (period_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (at_dec) shift_d = {vote, shift_q[DATA_BITS-1:1]};
        if (period_end) begin
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = parity_en ? S_PAR : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PAR: begin
        if (at_dec) begin
          perr_d  = parity_odd ? (vote != ~^shift_q) : (vote != ^shift_q);
          pzero_d = ~vote;
        end
        if (period_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (at_dec) begin
          if (!vote && bit_cnt_q == '0 && shift_q == '0 && pzero_q) begin
            // Whole frame low: report a break now and wait for the line to rise.
            done      = 1'b1;
            done_word = {1'b1, 1'b1, perr_q, {DATA_BITS{1'b0}}};
            state_d   = S_BRK;
          end else if (bit_cnt_q == BW'(two_stop)) begin
            // Leave mid stop bit so the next start edge is not missed.
            done      = 1'b1;
            done_word = {1'b0, ferr_q | ~vote, perr_q, shift_q};
            state_d   = S_IDLE;
          end else begin
            ferr_d = ferr_q | ~vote;
          end
        end else if (period_end) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_BRK: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output buffering
  logic          head_valid, pop, ovr_q;
  logic [WW-1:0] head_word;

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_q, rd_q;   // extra MSB tells full from empty
  logic          empty, full, push;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = !empty && rx_ready;
  assign push  = done && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= done && full && !pop;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // NOTE: the storage has no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= done_word;
  end

  assign head_valid = !empty;
  assign head_word  = mem_q[rd_q[AW-1:0]];
`else
  logic          hold_v_q;
  logic [WW-1:0] hold_w_q;

  assign pop = hold_v_q && rx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_v_q <= 1'b0;
      hold_w_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      ovr_q <= done && hold_v_q && !pop;
      if (done && (!hold_v_q || pop)) begin
        hold_w_q <= done_word;
        hold_v_q <= 1'b1;
      end else if (pop) begin
        hold_v_q <= 1'b0;
      end
    end
  end

  assign head_valid = hold_v_q;
  assign head_word  = hold_w_q;
`endif

  // Outputs are forced to 0 when nothing is presented.
  assign rx_valid   = head_valid;
  assign rx_data    = head_valid ? head_word[DATA_BITS-1:0] : '0;
  assign parity_err = head_valid & head_word[DATA_BITS];
  assign frame_err  = head_valid & head_word[DATA_BITS+1];
  assign break_det  = head_valid & head_word[DATA_BITS+2];
  assign overrun    = ovr_q;

endmodule
